// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: 2-flop synchronised rx, bit-centre sampling with start/stop
// checking, and a first-word-fall-through byte FIFO with valid/ready output.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state;
  logic             sync1;
  logic             rxs;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] p;
  logic [DIV_W-1:0] p_m1;
  logic [DIV_W-1:0] h_m1;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             stop_tick;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             ferr_set;
  logic             ovr_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  assign p    = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
  assign p_m1 = p - DIV_W'(1);
  assign h_m1 = (p >> 1) - DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == h_m1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        DATA: begin
          if (cnt == p_m1) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        STOP: begin
          if (cnt == p_m1) begin
            cnt   <= '0;
            state <= rxs ? IDLE : BREAK;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Push/frame decisions are taken in the stop-sample cycle; the FIFO registers them at the edge.
  assign stop_tick = (state == STOP) && (cnt == p_m1);
  assign push      = stop_tick && rxs;
  assign ferr_set  = stop_tick && !rxs;

  assign rx_valid   = (count != '0);
  assign pop        = rx_valid && rx_ready;
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign wr_en      = push && (!full || pop);
  assign ovr_set    = push && full && !pop;
  assign rx_data    = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

endmodule
